// File: rtl/systolic_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_if
// Bundles the host start/done handshake, the operand-feed / accumulator-clear
// controls and the row-wise result readout handshake of the systolic
// sequencer.
//
// Parameters
//   N_SIZE : array dimension (rows = cols = inner dimension)
//
// Signals
//   start     host -> ctrl   request a multiply
//   busy      ctrl -> host   controller not idle
//   done      ctrl -> host   last result row accepted this cycle
//   k_idx     ctrl -> array  operand fetch index (column of A / row of B)
//   feed_en   ctrl -> array  shift enable for all skew registers
//   pe_clear  ctrl -> array  clear all PE accumulators
//   out_valid ctrl -> sink   result row valid
//   out_row   ctrl -> sink   index of presented result row
//   out_ready sink -> ctrl   consumer accepts the presented row
//
// Modports
//   master : the controller
//   slave  : host / array / consumer side
// ---------------------------------------------------------------------------
interface systolic_ctrl_if #(
    parameter int N_SIZE = 5
);
    localparam int CNT_W = $clog2(2 * N_SIZE) + 1;
    localparam int ROW_W = $clog2(N_SIZE);

    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] k_idx;
    logic             feed_en;
    logic             pe_clear;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic             out_ready;

    modport master (
        input  start,
        input  out_ready,
        output busy,
        output done,
        output k_idx,
        output feed_en,
        output pe_clear,
        output out_valid,
        output out_row
    );

    modport slave (
        output start,
        output out_ready,
        input  busy,
        input  done,
        input  k_idx,
        input  feed_en,
        input  pe_clear,
        input  out_valid,
        input  out_row
    );
endinterface

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for one N_SIZE x N_SIZE systolic matrix multiply:
//   IDLE -> CLEAR (1 cycle accumulator clear)
//        -> FEED  (N_SIZE cycles, k_idx = 0..N_SIZE-1, skew registers shift)
//        -> DRAIN (2*N_SIZE-1 cycles, last operand crosses skew + array)
//        -> OUTPUT (one result row per out_valid/out_ready handshake)
//        -> IDLE  (done pulses on the acceptance of the last row)
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high; aborts any run without done
//   bus          systolic_ctrl_if.master (start/busy/done, feed controls,
//                result readout handshake)
//   perf_cycles  [31:0] busy-cycle counter, present only when the build
//                macro SYSTOLIC_CTRL_PERF_EN is defined
//
// Configuration
//   SYSTOLIC_CTRL_PERF_EN : adds perf_cycles. Undefined by default.
// ---------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int N_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_ctrl_if.master      bus
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam int CNT_W = $clog2(2 * N_SIZE) + 1;
    localparam int ROW_W = $clog2(N_SIZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(N_SIZE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * N_SIZE - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_SIZE - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_q;
    logic             pe_clear_q;
    logic             feed_en_q;
    logic [CNT_W-1:0] k_idx_q;
    logic             out_valid_q;
    logic [ROW_W-1:0] out_row_q;

    logic             handshake;
    logic             last_row;

    assign handshake = out_valid_q && bus.out_ready;
    assign last_row  = (out_row_q == ROW_LAST);

    // ------------------------------------------------------------------
    // Next-state logic. One counter serves every phase: FEED index, DRAIN
    // hold time and OUTPUT row number. It restarts at zero whenever the
    // state changes, so each phase counts from 0.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (handshake) begin
                    if (last_row) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State, counter and output registers. Outputs are decoded from the
    // next state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            pe_clear_q  <= 1'b0;
            feed_en_q   <= 1'b0;
            k_idx_q     <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != S_IDLE);
            pe_clear_q  <= (state_d == S_CLEAR);
            feed_en_q   <= (state_d == S_FEED);
            k_idx_q     <= (state_d == S_FEED) ? cnt_d : '0;
            out_valid_q <= (state_d == S_OUTPUT);
            out_row_q   <= (state_d == S_OUTPUT) ? cnt_d[ROW_W-1:0] : '0;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pe_clear  = pe_clear_q;
    assign bus.feed_en   = feed_en_q;
    assign bus.k_idx     = k_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;

    // done marks the cycle in which the last row is accepted, so it has to
    // be qualified by out_ready of that very cycle; it is gated by
    // registered state only, which keeps it glitch-free and keeps busy high
    // while done is asserted (a start seen together with done is ignored).
    assign bus.done = handshake && last_row;

`ifdef SYSTOLIC_CTRL_PERF_EN
    // The accept cycle is counted as the first cycle of the run, so a run
    // reads from its start cycle through its done cycle inclusive.
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            perf_q <= 32'd1;
        end else if (state_q != S_IDLE && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int N = 5;
    localparam int T_OUT = 3 * N + 1;   // cycles from accept to first out_valid

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.N_SIZE(N)) sif ();

    systolic_ctrl #(.N_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Observation word: {busy,done,feed_en,pe_clear,out_valid} | k_idx | out_row
    function automatic logic [31:0] pack(logic b, logic d, logic f, logic p, logic v,
                                         logic [7:0] k, logic [7:0] r);
        return {11'd0, b, d, f, p, v, k, r};
    endfunction

    function automatic logic [31:0] obs();
        return pack(sif.busy, sif.done, sif.feed_en, sif.pe_clear, sif.out_valid,
                    8'(sif.k_idx), 8'(sif.out_row));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got busy,done,feed,clr,val=%b k=%0d row=%0d | expected busy,done,feed,clr,val=%b k=%0d row=%0d",
                     nm, $time, act[20:16], act[15:8], act[7:0], exp[20:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic chk_val(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return at the
    // falling edge where outputs are sampled.
    task automatic cyc_in(logic s, logic r, logic rs);
        @(posedge clk);
        #1;
        sif.start     = s;
        sif.out_ready = r;
        rst           = rs;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Behavioural PE array with input skew, driven by the controller.
    // Lane i of A and lane j of B are delayed by i+1 / j+1 cycles.
    // ------------------------------------------------------------------
    int mat_a [N][N];
    int mat_b [N][N];
    int sa    [N][N];
    int sb    [N][N];
    int pa    [N][N];
    int pb    [N][N];
    int acc   [N][N];

    function automatic int left_in(int i, int j);
        return (j == 0) ? sa[i][i] : pa[i][j-1];
    endfunction

    function automatic int top_in(int i, int j);
        return (i == 0) ? sb[j][j] : pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            sa[i][0] <= sif.feed_en ? mat_a[i][sif.k_idx] : 0;
            sb[i][0] <= sif.feed_en ? mat_b[sif.k_idx][i] : 0;
            for (int m = 1; m < N; m++) begin
                sa[i][m] <= sa[i][m-1];
                sb[i][m] <= sb[i][m-1];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa[i][j]  <= left_in(i, j);
                pb[i][j]  <= top_in(i, j);
                acc[i][j] <= sif.pe_clear ? 0 : acc[i][j] + left_in(i, j) * top_in(i, j);
            end
        end
    end

    // ------------------------------------------------------------------
    // Table-driven basic run: cycle 0 carries start; extra start pulses in
    // FEED (cycle 4) and on the done cycle (cycle 20) must be ignored.
    // ------------------------------------------------------------------
    typedef struct {
        logic        start;
        logic        ready;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    // Bench-side reference model for random traffic: time since accept and
    // number of rows already accepted.
    bit m_busy;
    int m_t;
    int m_r;

    initial begin
        logic [31:0] e;
        logic        s, r, rs;
        int          row;

        for (int c = 0; c < NV; c++) begin
            tv[c].start = 1'b0;
            tv[c].ready = 1'b1;
            tv[c].exp   = pack(0, 0, 0, 0, 0, 8'd0, 8'd0);
        end
        tv[0].start = 1'b1;
        tv[4].start = 1'b1;
        tv[20].start = 1'b1;
        tv[1].exp = pack(1, 0, 0, 1, 0, 8'd0, 8'd0);
        for (int c = 2; c <= 6; c++)   tv[c].exp = pack(1, 0, 1, 0, 0, 8'(c - 2), 8'd0);
        for (int c = 7; c <= 15; c++)  tv[c].exp = pack(1, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int c = 16; c <= 20; c++) tv[c].exp = pack(1, (c == 20), 0, 0, 1, 8'd0, 8'(c - 16));

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = (i == j) ? 1 : 0;
                mat_b[i][j] = i * N + j + 1;
            end
        end

        sif.start     = 1'b0;
        sif.out_ready = 1'b0;

        // Reset state
        cyc_in(0, 0, 1);
        cyc_in(0, 0, 1);
        chk("reset_state", obs(), pack(0, 0, 0, 0, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 0);
        chk("idle_after_reset", obs(), pack(0, 0, 0, 0, 0, 8'd0, 8'd0));

        // Basic run from the table, with end-to-end row checks on handshakes
        for (int c = 0; c < NV; c++) begin
            cyc_in(tv[c].start, tv[c].ready, 0);
            chk($sformatf("basic_c%0d", c), obs(), tv[c].exp);
            if (tv[c].exp[16] && tv[c].ready) begin
                row = int'(tv[c].exp[7:0]);
                for (int j = 0; j < N; j++) begin
                    chk_val($sformatf("result_r%0d_c%0d", row, j), acc[row][j], mat_b[row][j]);
                end
            end
        end

        // Reset for 2 cycles in the middle of FEED
        cyc_in(1, 1, 0);
        cyc_in(0, 1, 0);
        chk("rst_seq_clear", obs(), pack(1, 0, 0, 1, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 0);
        chk("rst_seq_feed0", obs(), pack(1, 0, 1, 0, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 1);
        chk("rst_seq_feed1", obs(), pack(1, 0, 1, 0, 0, 8'd1, 8'd0));
        cyc_in(0, 1, 1);
        chk("rst_seq_idle1", obs(), pack(0, 0, 0, 0, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 0);
        chk("rst_seq_idle2", obs(), pack(0, 0, 0, 0, 0, 8'd0, 8'd0));
        cyc_in(1, 1, 0);
        chk("rst_seq_restart_idle", obs(), pack(0, 0, 0, 0, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 0);
        chk("rst_seq_restart_clear", obs(), pack(1, 0, 0, 1, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 0);
        chk("rst_seq_restart_feed", obs(), pack(1, 0, 1, 0, 0, 8'd0, 8'd0));
        cyc_in(0, 1, 1);
        cyc_in(0, 1, 0);

        // Backpressure: out_ready low for 3 cycles while row 2 is presented
        for (int c = 0; c <= 25; c++) begin
            s = (c == 0);
            r = !(c >= 18 && c <= 20);
            cyc_in(s, r, 0);
            if (c >= 15) begin
                if (c == 15) e = pack(1, 0, 0, 0, 0, 8'd0, 8'd0);
                else if (c <= 23) begin
                    row = (c < 18) ? c - 16 : (c <= 21) ? 2 : c - 19;
                    e = pack(1, (c == 23), 0, 0, 1, 8'd0, 8'(row));
                end else e = pack(0, 0, 0, 0, 0, 8'd0, 8'd0);
                chk($sformatf("bp_c%0d", c), obs(), e);
            end
        end

        // Randomized traffic against the reference model
        cyc_in(0, 0, 1);
        m_busy = 1'b0;
        m_t    = 0;
        m_r    = 0;
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 199) == 0);
            cyc_in(s, r, rs);
            begin
                logic b, d, f, p, v;
                int   k, ro;
                b  = m_busy;
                p  = m_busy && (m_t == 1);
                f  = m_busy && (m_t >= 2) && (m_t <= N + 1);
                k  = f ? m_t - 2 : 0;
                v  = m_busy && (m_t >= T_OUT);
                ro = v ? m_r : 0;
                d  = v && (m_r == N - 1) && r;
                chk($sformatf("rand_%0d", i), obs(), pack(b, d, f, p, v, 8'(k), 8'(ro)));
            end
            // model advance for the coming edge
            if (rs) begin
                m_busy = 1'b0;
                m_t    = 0;
                m_r    = 0;
            end else if (!m_busy) begin
                if (s) begin
                    m_busy = 1'b1;
                    m_t    = 1;
                    m_r    = 0;
                end
            end else begin
                if (m_t >= T_OUT && r) begin
                    if (m_r == N - 1) m_busy = 1'b0;
                    else m_r = m_r + 1;
                end
                m_t = m_t + 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
